// File: rtl/chronos_pkg.sv
// Shared constants for the front end: architectural defaults and the canonical NOP.
package chronos_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction memory request/response, redirect, and decode handoff.
interface fetch_unit_if
  import chronos_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head word is visible combinationally.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response capture into a
// queue, and kill-and-redirect that drops responses still owed to the old path.
module fetch_unit
  import chronos_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              QDEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] pc, resp_pc, redir_pc;
  logic [CW-1:0]   inflight, drop_cnt, count;
  logic [CW:0]     credit_used;
  logic            full, empty, accept, resp_ok, push, pop;
  logic [EW-1:0]   head;

  assign redir_pc    = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used = {1'b0, count} + {1'b0, inflight};

  // Every outstanding request owns a queue slot, so a response can always be pushed.
  assign bus.imem_req  = !rst && !bus.redirect && !full && (credit_used < (CW+1)'(QDEPTH));
  assign bus.imem_addr = pc;
  assign accept        = bus.imem_req && bus.imem_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_ok = !rst && bus.imem_rvalid && (inflight != '0);
  assign push    = resp_ok && !bus.redirect && (drop_cnt == '0);
  assign pop     = !rst && !bus.redirect && !empty && bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (bus.redirect) begin
      // Everything still owed belongs to the killed path; a response landing now is dropped.
      pc       <= redir_pc;
      resp_pc  <= redir_pc;
      inflight <= inflight - CW'(resp_ok);
      drop_cnt <= inflight - CW'(resp_ok);
    end else begin
      if (accept) pc <= pc + XLEN'(4);
      if (push) resp_pc <= resp_pc + XLEN'(4);
      inflight <= inflight + CW'(accept) - CW'(resp_ok);
      if (resp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .din   ({resp_pc, bus.imem_rdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.id_valid = !empty;
  assign bus.id_inst  = empty ? NOP_INST : head[31:0];
  assign bus.id_pc    = head[EW-1:32];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit; the bench plays instruction memory and
// predicts the decode stream from request addresses and path epochs.
module tb_fetch_unit;
  import chronos_pkg::*;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit stale; } req_t;

  ent_t        mq[$];    // what decode should see, in order
  req_t        outq[$];  // requests the memory still owes
  logic [31:0] mpc;
  int vectors = 0, errors = 0, cyc = 0, dut_acc = 0, first_req = -1, first_vld = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                      input int pr, input int pi, input int pv, input bit spur = 1'b0);
    bit   exp_req, resp;
    req_t o;
    @(negedge clk);
    cyc++;
    rst             = r;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_ready  = ($urandom_range(99) < pr);
    bus.id_ready    = ($urandom_range(99) < pi);
    if (outq.size() > 0 && $urandom_range(99) < pv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = outq[0].data;
    end else begin
      bus.imem_rvalid = spur && (outq.size() == 0);
      bus.imem_rdata  = $urandom;
    end
    #1;
    exp_req = !r && !redir && (mq.size() + outq.size() < QD);
    chk("imem_req", bus.imem_req, exp_req);
    chk("imem_addr", bus.imem_addr, mpc);
    chk("id_valid", bus.id_valid, mq.size() > 0);
    chk("id_inst", bus.id_inst, (mq.size() > 0) ? mq[0].inst : NOP_INST);
    if (mq.size() > 0) chk("id_pc", bus.id_pc, mq[0].pc);
    if (bus.imem_req && bus.imem_ready) begin
      dut_acc++;
      if (first_req < 0) first_req = cyc;
    end
    if (bus.id_valid && first_vld < 0) first_vld = cyc;

    resp = bus.imem_rvalid && (outq.size() > 0);
    if (r) begin
      mq.delete();
      outq.delete();
      mpc = RPC;
    end else if (redir) begin
      if (resp) void'(outq.pop_front());
      foreach (outq[i]) outq[i].stale = 1'b1;
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (bus.id_ready && mq.size() > 0) void'(mq.pop_front());
      if (resp) begin
        o = outq.pop_front();
        if (!o.stale) mq.push_back('{pc: o.pc, inst: o.data});
      end
      if (exp_req && bus.imem_ready) begin
        outq.push_back('{pc: mpc, data: $urandom, stale: 1'b0});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    mpc = RPC;

    // Streaming from reset; RESET_PC near the top also exercises PC wrap to 0.
    first_req = -1; first_vld = -1;
    repeat (4) step(0, 0, '0, 100, 100, 100);
    a0 = dut_acc;
    repeat (8) step(0, 0, '0, 100, 100, 100);
    chk("req_to_valid_latency", first_vld - first_req, 2);
    chk("stream_rate", dut_acc - a0, 8);

    // Backpressure: credit caps acceptances at the queue depth, then drains in order.
    step(1, 0, '0, 100, 100, 100);
    a0 = dut_acc;
    repeat (10) step(0, 0, '0, 100, 0, 100);
    chk("bp_accepts", dut_acc - a0, QD);
    repeat (6) step(0, 0, '0, 0, 100, 100);

    // Redirect with two requests outstanding.
    step(1, 0, '0, 100, 100, 100);
    repeat (2) step(0, 0, '0, 100, 0, 0);
    step(0, 1, 32'h0000_0102, 100, 100, 0);
    repeat (4) step(0, 0, '0, 100, 0, 100);
    chk("redir_head", bus.id_pc, 32'h0000_0100);
    step(0, 0, '0, 100, 100, 100);
    step(0, 0, '0, 100, 0, 100);
    chk("redir_next", bus.id_pc, 32'h0000_0104);

    // Redirect coinciding with a response and a pop request.
    step(1, 0, '0, 100, 100, 100);
    repeat (2) step(0, 0, '0, 100, 0, 0);
    step(0, 0, '0, 0, 0, 100);
    step(0, 0, '0, 100, 0, 0);
    step(0, 1, 32'h0000_0200, 100, 100, 100);
    repeat (3) step(0, 0, '0, 100, 100, 100);
    chk("coinc_head", bus.id_pc, 32'h0000_0200);
    repeat (4) step(0, 0, '0, 100, 100, 100);

    // Spurious response with nothing outstanding.
    step(1, 0, '0, 0, 100, 0);
    repeat (3) step(0, 0, '0, 0, 100, 0, 1);
    repeat (4) step(0, 0, '0, 100, 100, 100);

    // One-cycle reset pulse mid-stream.
    repeat (5) step(0, 0, '0, 100, 100, 100);
    step(1, 0, '0, 100, 100, 100);
    step(0, 0, '0, 100, 100, 100);
    chk("post_rst_valid", bus.id_valid, 1'b0);
    chk("post_rst_inst", bus.id_inst, 32'h0000_0013);
    chk("post_rst_pc", bus.imem_addr, RPC);
    repeat (4) step(0, 0, '0, 100, 100, 100);

    // Randomized traffic with occasional redirects and resets.
    repeat (800) begin
      step($urandom_range(99) < 1, $urandom_range(99) < 6, $urandom,
           70, 60, 60, $urandom_range(9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter RESET_PC, default 0, PC value after reset.
REQ-003 Parameter QDEPTH, default 4, fetch-queue entries; power of two, at least 2.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port imem_req  output  1  fetch request valid.
REQ-007 Port imem_addr  output  XLEN  fetch address, equal to PC.
REQ-008 Port imem_ready  input  1  memory accepts the request this cycle.
REQ-009 Port imem_rvalid  input  1  response valid; responses return in request order.
REQ-010 Port imem_rdata  input  32  response instruction word.
REQ-011 Port redirect  input  1  branch/jump resolution kill-and-redirect.
REQ-012 Port redirect_pc  input  XLEN  new fetch PC.
REQ-013 Port id_ready  input  1  decode stage accepts the head entry.
REQ-014 Port id_valid  output  1  head entry valid.
REQ-015 Port id_inst  output  32  head instruction, or NOP_INST when the queue is empty.
REQ-016 Port id_pc  output  XLEN  PC of the head instruction.

Function
REQ-017 A request is accepted when imem_req and imem_ready are both 1; on acceptance, PC advances by 4, modulo 2^XLEN (wraps).
REQ-018 imem_req is 1 only when rst=0, redirect=0, and (queue occupancy + inflight) < QDEPTH (credit rule; the queue never overflows).
REQ-019 inflight is the count of accepted requests not yet answered: +1 per acceptance, -1 per imem_rvalid, unchanged when both occur in one cycle.
REQ-020 A response with drop_cnt=0 pushes {resp_pc, imem_rdata}; resp_pc then advances by 4.
REQ-021 A response with drop_cnt>0 is discarded and drop_cnt decrements by 1.
REQ-022 imem_rvalid with inflight=0 is a protocol violation and is ignored; no state changes.
REQ-023 id_valid = queue non-empty; id_inst/id_pc present the head entry combinationally from queue state.
REQ-024 Pop occurs when id_valid and id_ready are both 1; a push and a pop in the same cycle leave occupancy unchanged.
REQ-025 Redirect cycle effects:
- queue flushed;
- PC and resp_pc set to {redirect_pc[XLEN-1:2], 2'b00};
- drop_cnt set to inflight minus any response arriving that cycle;
- that response is discarded;
- pop ignored;
- no request issued.
REQ-026 The first request after redirect issues the cycle following the redirect cycle, given that credit is available.
REQ-027 With imem_ready held 1, responses returning next cycle, and id_ready=1, the unit sustains one instruction per cycle; request-to-id_valid latency is 2 cycles.
REQ-028 Counters (occupancy, inflight, drop_cnt) are $clog2(QDEPTH)+1 bits wide and never wrap.

Reset
REQ-029 While rst=1, at each clock edge:
- PC and resp_pc load RESET_PC;
- occupancy, inflight and drop_cnt load 0;
- id_valid=0, id_inst=NOP_INST, imem_req=0.
REQ-030 A response arriving during reset is discarded.
REQ-031 Requests in flight across reset deassertion are not tracked; the memory side is reset concurrently.

Structure
REQ-032 Package chronos_pkg holds NOP_INST (32'h00000013, addi x0,x0,0), the XLEN default and the RESET_PC default.
REQ-033 The queue is a sub-module fetch_fifo: synchronous FIFO, parameterised width and depth, with flush input, full/empty/count outputs.
REQ-034 fetch_unit contains the PC, resp_pc, inflight and drop_cnt logic and instantiates one fetch_fifo with width XLEN+32.

Verification
REQ-035 Reset then streaming: release rst, imem_ready=1, 1-cycle response, id_ready=1 -> id_pc sequence 0x0,0x4,0x8,... one per cycle, first id_valid 2 cycles after first request.
REQ-036 Backpressure: id_ready=0 for 10 cycles, QDEPTH=4 -> exactly 4 requests accepted, imem_req=0 thereafter, no entry lost; id_ready=1 -> entries pop in order.
REQ-037 Redirect with 2 in flight: redirect_pc=0x100 -> queue empties, next 2 responses discarded, next id_pc=0x100, then 0x104.
REQ-038 Redirect coincident with response and pop: that response is dropped, no pop, drop_cnt = inflight-1.
REQ-039 PC wrap: RESET_PC=0xFFFFFFF8 -> id_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-040 Mid-stream rst pulse of 1 cycle -> id_valid=0 and id_inst=0x00000013 next cycle, restart from RESET_PC, stale responses dropped.
